// File: rtl/ddr_bw_pkg.sv
// Shared types and constants for the DDR bandwidth transfer path.
package ddr_bw_pkg;

  localparam int unsigned ADDR_W          = 32;
  localparam int unsigned CNT_W           = 32;
  localparam int unsigned NCHUNK_W        = 16;
  localparam int unsigned BYTES_PER_BURST = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_INCR,
    ST_WAIT_CMD,
    ST_DRAIN,
    ST_FIN
  } xfer_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  nbursts;
  } ddr_cmd_t;

endpackage

// File: rtl/ddr_xfer_ctrl.sv
// Sequences an address generator chunk by chunk and issues one write-master
// command per chunk, with abort, timeout and per-transfer statistics.
module ddr_xfer_ctrl
  import ddr_bw_pkg::*;
#(
  parameter int unsigned UNIT_BURSTS    = 128,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                start,
  input  logic                abort,
  output logic                latch_en,
  output logic                incr_en,
  input  logic [ADDR_W-1:0]   gen_addr,
  input  logic [CNT_W-1:0]    gen_nbursts,
  input  logic                gen_pending,
  input  logic                gen_done,
  output logic                cmd_valid,
  input  logic                cmd_ready,
  output logic [ADDR_W-1:0]   cmd_addr,
  output logic [CNT_W-1:0]    cmd_nbursts,
  output logic                busy,
  output logic                xfer_done,
  output logic                err,
  output logic [NCHUNK_W-1:0] nchunks,
  output logic [CNT_W-1:0]    ncycles
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  if (UNIT_BURSTS == 0 || (UNIT_BURSTS & (UNIT_BURSTS - 1)) != 0) begin : g_bad_unit
    $error("UNIT_BURSTS must be a power of 2");
  end

  xfer_state_e         state_q, state_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic                cap_q, cap_d;
  ddr_cmd_t            cmd_q, cmd_d;
  logic                cmd_valid_d, latch_en_d, incr_en_d, busy_d, xfer_done_d, err_d;
  logic [NCHUNK_W-1:0] nchunks_d;
  logic [CNT_W-1:0]    ncycles_d;
  logic                hs, tmo_hit, tmo_fin;

  assign hs          = cmd_valid && cmd_ready;
  assign tmo_hit     = (tmo_q == TMO_W'(TIMEOUT_CYCLES));
  assign cmd_addr    = cmd_q.addr;
  assign cmd_nbursts = cmd_q.nbursts;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      tmo_q     <= '0;
      cap_q     <= 1'b0;
      cmd_q     <= '0;
      cmd_valid <= 1'b0;
      latch_en  <= 1'b0;
      incr_en   <= 1'b0;
      busy      <= 1'b0;
      xfer_done <= 1'b0;
      err       <= 1'b0;
      nchunks   <= '0;
      ncycles   <= '0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      cap_q     <= cap_d;
      cmd_q     <= cmd_d;
      cmd_valid <= cmd_valid_d;
      latch_en  <= latch_en_d;
      incr_en   <= incr_en_d;
      busy      <= busy_d;
      xfer_done <= xfer_done_d;
      err       <= err_d;
      nchunks   <= nchunks_d;
      ncycles   <= ncycles_d;
    end
  end

  // Next state: abort beats timeout beats normal progress; a pending handshake beats abort
  always_comb begin
    state_d = state_q;
    tmo_fin = 1'b0;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_LATCH;
      ST_LATCH: state_d = abort ? ST_FIN : ST_INCR;
      ST_INCR:  state_d = abort ? ST_FIN : ST_WAIT_CMD;
      ST_WAIT_CMD: begin
        if (hs) begin
          state_d = ST_DRAIN;
        end else if (abort) begin
          state_d = ST_FIN;
        end else if (tmo_hit) begin
          state_d = ST_FIN;
          tmo_fin = 1'b1;
        end else if (cap_q && gen_nbursts == '0) begin
          state_d = ST_FIN;
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_FIN;
        end else if (tmo_hit) begin
          state_d = ST_FIN;
          tmo_fin = 1'b1;
        end else if (!gen_pending) begin
          state_d = gen_done ? ST_FIN : ST_INCR;
        end
      end
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output next values, aligned so each registered output tracks the state it belongs to
  always_comb begin
    latch_en_d  = (state_d == ST_LATCH);
    incr_en_d   = (state_d == ST_INCR);
    busy_d      = (state_d != ST_IDLE);
    xfer_done_d = (state_d == ST_FIN);
    cap_d       = (state_q == ST_INCR) && (state_d == ST_WAIT_CMD);
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid;
    err_d       = err;
    nchunks_d   = nchunks;
    ncycles_d   = ncycles;
    tmo_d       = tmo_q;

    // Generator outputs settle the cycle after incr_en, so sample them then
    if (cap_q) begin
      cmd_d.addr    = gen_addr;
      cmd_d.nbursts = gen_nbursts;
      cmd_valid_d   = 1'b1;
    end
    if (state_d != ST_WAIT_CMD) cmd_valid_d = 1'b0;

    if (state_d == ST_LATCH) begin
      err_d     = 1'b0;
      nchunks_d = '0;
      ncycles_d = CNT_W'(1);
    end else begin
      if (tmo_fin) err_d = 1'b1;
      if (state_q == ST_WAIT_CMD && hs) nchunks_d = nchunks + NCHUNK_W'(1);
      if (state_d != ST_IDLE && ncycles != '1) ncycles_d = ncycles + CNT_W'(1);
    end

    if (state_d != state_q) begin
      tmo_d = '0;
    end else if ((state_q == ST_WAIT_CMD || state_q == ST_DRAIN) && !tmo_hit) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

endmodule

// File: tb/tb_ddr_xfer_ctrl.sv
// Directed bench for ddr_xfer_ctrl with a behavioural chunking address generator.
module tb_ddr_xfer_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        latch_en, incr_en;
  logic [31:0] gen_addr, gen_nbursts;
  logic        gen_pending, gen_done;
  logic        cmd_valid;
  logic        cmd_ready = 1'b1;
  logic [31:0] cmd_addr, cmd_nbursts;
  logic        busy, xfer_done, err;
  logic [15:0] nchunks;
  logic [31:0] ncycles;

  int checks = 0;
  int errors = 0;

  ddr_xfer_ctrl #(.UNIT_BURSTS(128), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .latch_en(latch_en), .incr_en(incr_en),
    .gen_addr(gen_addr), .gen_nbursts(gen_nbursts),
    .gen_pending(gen_pending), .gen_done(gen_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_nbursts(cmd_nbursts),
    .busy(busy), .xfer_done(xfer_done), .err(err),
    .nchunks(nchunks), .ncycles(ncycles)
  );

  always #5 clk = ~clk;

  // Address generator model: 128-burst chunks, data written 2 cycles after each command
  logic [31:0] cfg_addr = '0, cfg_nb = '0;
  logic [31:0] nxt_addr, rem, chunk_n;
  logic [1:0]  wr_cnt;
  logic        stuck = 1'b0;
  assign chunk_n  = (rem > 32'd128) ? 32'd128 : rem;
  assign gen_done = (rem == 32'd0);

  always @(posedge clk) begin
    if (!rstn) begin
      gen_addr <= '0; gen_nbursts <= '0; nxt_addr <= '0; rem <= '0;
      gen_pending <= 1'b0; wr_cnt <= '0;
    end else begin
      if (latch_en) begin
        nxt_addr <= cfg_addr;
        rem      <= cfg_nb;
      end
      if (incr_en) begin
        gen_addr    <= nxt_addr;
        gen_nbursts <= chunk_n;
        nxt_addr    <= nxt_addr + chunk_n * 32'd128;
        rem         <= rem - chunk_n;
        gen_pending <= (chunk_n != 32'd0);
      end
      if (cmd_valid && cmd_ready) begin
        wr_cnt <= 2'd2;
      end else if (wr_cnt != 2'd0) begin
        wr_cnt <= wr_cnt - 2'd1;
        if (wr_cnt == 2'd1 && !stuck) gen_pending <= 1'b0;
      end
    end
  end

  // Event recorder
  logic [31:0] hs_addr[$], hs_nb[$];
  int ndone = 0, nlatch = 0, nincr = 0, both = 0;
  always @(posedge clk) begin
    if (cmd_valid && cmd_ready) begin
      hs_addr.push_back(cmd_addr);
      hs_nb.push_back(cmd_nbursts);
    end
    if (xfer_done) ndone++;
    if (latch_en) nlatch++;
    if (incr_en) nincr++;
    if (latch_en && incr_en) both++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cmd_valid !== 1'b1 && n < 50);
    check({tag, "_valid_seen"}, 32'(cmd_valid), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, d0, stable, done_at;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_nchunks", 32'(nchunks), 32'd0);
    check("rst_ncycles", ncycles, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    // 300 bursts: three chunks 128/128/44
    cfg_addr = 32'h1000_0000; cfg_nb = 32'd300;
    base = hs_addr.size(); d0 = ndone; nlatch = 0; nincr = 0;
    pulse_start();
    check("t1_latch_pulse", 32'(latch_en), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    wait_idle("t1");
    check("t1_ncmd", 32'(hs_addr.size() - base), 32'd3);
    if (hs_addr.size() >= base + 3) begin
      check("t1_addr0", hs_addr[base], 32'h1000_0000);
      check("t1_nb0", hs_nb[base], 32'd128);
      check("t1_addr1", hs_addr[base+1], 32'h1000_4000);
      check("t1_nb1", hs_nb[base+1], 32'd128);
      check("t1_addr2", hs_addr[base+2], 32'h1000_8000);
      check("t1_nb2", hs_nb[base+2], 32'd44);
    end
    check("t1_nchunks", 32'(nchunks), 32'd3);
    check("t1_done", 32'(ndone - d0), 32'd1);
    check("t1_ncycles", ncycles, 32'd20);
    check("t1_err", 32'(err), 32'd0);
    check("t1_nlatch", 32'(nlatch), 32'd1);
    check("t1_nincr", 32'(nincr), 32'd3);

    // cmd_ready held low for 10 cycles
    cmd_ready = 1'b0;
    cfg_addr = 32'h3000_0080; cfg_nb = 32'd64;
    base = hs_addr.size(); d0 = ndone;
    pulse_start();
    wait_valid("t3");
    stable = 0;
    for (int i = 0; i < 10; i++) begin
      if (cmd_valid === 1'b1 && cmd_addr === 32'h3000_0080 && cmd_nbursts === 32'd64) stable++;
      @(negedge clk);
    end
    check("t3_stable_cycles", 32'(stable), 32'd10);
    check("t3_no_hs_yet", 32'(hs_addr.size() - base), 32'd0);
    cmd_ready = 1'b1;
    wait_idle("t3");
    check("t3_ncmd", 32'(hs_addr.size() - base), 32'd1);
    check("t3_nchunks", 32'(nchunks), 32'd1);
    check("t3_ncycles", ncycles, 32'd18);
    check("t3_done", 32'(ndone - d0), 32'd1);

    // Timeout in DRAIN with gen_pending stuck
    stuck = 1'b1;
    cfg_addr = 32'h4000_0000; cfg_nb = 32'd50;
    d0 = ndone;
    pulse_start();
    wait_valid("t4");
    done_at = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (xfer_done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    check("t4_done_after_hs", 32'(done_at), 32'd18);
    check("t4_err", 32'(err), 32'd1);
    stuck = 1'b0;
    wait_idle("t4");
    check("t4_err_sticky", 32'(err), 32'd1);
    check("t4_ncycles", ncycles, 32'd22);
    check("t4_done", 32'(ndone - d0), 32'd1);

    // Abort in DRAIN
    cfg_addr = 32'h5000_0000; cfg_nb = 32'd300;
    base = hs_addr.size(); d0 = ndone;
    pulse_start();
    check("t5_err_cleared", 32'(err), 32'd0);
    wait_valid("t5");
    @(negedge clk) abort = 1'b1;
    @(negedge clk);
    check("t5_fin_pulse", 32'(xfer_done), 32'd1);
    check("t5_err", 32'(err), 32'd0);
    abort = 1'b0;
    @(negedge clk);
    check("t5_idle_next", 32'(busy), 32'd0);
    check("t5_done", 32'(ndone - d0), 32'd1);
    check("t5_nchunks", 32'(nchunks), 32'd1);
    check("t5_ncycles", ncycles, 32'd6);

    // 128 bursts: single command, done after first drain
    cfg_addr = 32'h2000_0000; cfg_nb = 32'd128;
    base = hs_addr.size(); d0 = ndone;
    pulse_start();
    wait_idle("t2");
    check("t2_ncmd", 32'(hs_addr.size() - base), 32'd1);
    if (hs_addr.size() >= base + 1) begin
      check("t2_addr", hs_addr[base], 32'h2000_0000);
      check("t2_nb", hs_nb[base], 32'd128);
    end
    check("t2_nchunks", 32'(nchunks), 32'd1);
    check("t2_ncycles", ncycles, 32'd8);
    check("t2_done", 32'(ndone - d0), 32'd1);

    // Zero-length transfer
    cfg_addr = 32'h6000_0000; cfg_nb = 32'd0;
    base = hs_addr.size(); d0 = ndone;
    pulse_start();
    wait_idle("t6");
    check("t6_ncmd", 32'(hs_addr.size() - base), 32'd0);
    check("t6_nchunks", 32'(nchunks), 32'd0);
    check("t6_ncycles", ncycles, 32'd4);
    check("t6_done", 32'(ndone - d0), 32'd1);

    // Reset mid-DRAIN
    cfg_addr = 32'h7000_0000; cfg_nb = 32'd300;
    d0 = ndone;
    pulse_start();
    wait_valid("t7");
    @(negedge clk) rstn = 1'b0;
    @(negedge clk);
    check("t7_busy", 32'(busy), 32'd0);
    check("t7_cmd_valid", 32'(cmd_valid), 32'd0);
    check("t7_cmd_addr", cmd_addr, 32'd0);
    check("t7_cmd_nb", cmd_nbursts, 32'd0);
    check("t7_en", {30'd0, latch_en, incr_en}, 32'd0);
    check("t7_err", 32'(err), 32'd0);
    check("t7_nchunks", 32'(nchunks), 32'd0);
    check("t7_ncycles", ncycles, 32'd0);
    rstn = 1'b1;
    repeat (5) @(negedge clk);
    check("t7_no_done", 32'(ndone - d0), 32'd0);
    check("t7_still_idle", 32'(busy), 32'd0);

    check("latch_incr_overlap", 32'(both), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ddr_xfer_ctrl.md
DDR_XFER_CTRL -- requirements
Module: ddr_xfer_ctrl

Interface
REQ-001 SHALL have parameter UNIT_BURSTS, default 128: maximum bursts per chunk command; power of 2.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 65535: maximum cycles allowed in WAIT_CMD or DRAIN before abort with error.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rstn  input  1  synchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse; begins a transfer using the cfg word currently held by the address generator.
REQ-006 SHALL have port abort  input  1  level; aborts the transfer in progress.
REQ-007 SHALL have port latch_en  output  1  to address generator; latches cfg.
REQ-008 SHALL have port incr_en  output  1  to address generator; advances to the next chunk.
REQ-009 SHALL have port gen_addr  input  32  chunk start byte address from the address generator.
REQ-010 SHALL have port gen_nbursts  input  32  chunk burst count from the address generator.
REQ-011 SHALL have port gen_pending  input  1  chunk data not yet fully written.
REQ-012 SHALL have port gen_done  input  1  no bursts remain.
REQ-013 SHALL have port cmd_valid  output  1  write-master command valid.
REQ-014 SHALL have port cmd_ready  input  1  write-master command accept.
REQ-015 SHALL have port cmd_addr  output  32  command byte address.
REQ-016 SHALL have port cmd_nbursts  output  32  command burst count.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port xfer_done  output  1  one-cycle pulse on completion, abort or error.
REQ-019 SHALL have port err  output  1  sticky timeout flag; cleared by the next start.
REQ-020 SHALL have port nchunks  output  16  commands accepted in the current/last transfer.
REQ-021 SHALL have port ncycles  output  32  cycles from LATCH to FIN inclusive; saturates at 0xFFFFFFFF.

Function
REQ-022 SHALL implement an FSM with states IDLE, LATCH, INCR, WAIT_CMD, DRAIN, FIN.
REQ-023 SHALL go IDLE->LATCH on start; start outside IDLE is ignored.
REQ-024 SHALL assert latch_en for exactly one cycle in LATCH, then go to INCR.
REQ-025 SHALL assert incr_en for exactly one cycle in INCR, then go to WAIT_CMD.
REQ-026 SHALL capture gen_addr and gen_nbursts into cmd_addr/cmd_nbursts on WAIT_CMD entry (cycle after incr_en) and hold cmd_valid high until cmd_valid&&cmd_ready; cmd_addr and cmd_nbursts are stable while cmd_valid is high.
REQ-027 SHALL, on handshake, increment nchunks (wraps at 16 bits) and go to DRAIN.
REQ-028 SHALL leave DRAIN when gen_pending==0: to FIN if gen_done==1, else to INCR.
REQ-029 SHALL treat a captured cmd_nbursts of 0 as zero-length: skip the command, do not increment nchunks, go directly to FIN.
REQ-030 SHALL, in FIN, pulse xfer_done for one cycle and return to IDLE.
REQ-031 SHALL, while in WAIT_CMD or DRAIN, count cycles in that state; on reaching TIMEOUT_CYCLES, set err, drop cmd_valid and go to FIN.
REQ-032 SHALL, on abort in LATCH, INCR or DRAIN, go to FIN next cycle; in WAIT_CMD, abort is honoured only when cmd_valid is not mid-handshake (cmd_ready==0). If abort and cmd_ready arrive together, the handshake completes first.
REQ-033 SHALL give abort priority over timeout and over DRAIN exit in the same cycle.
REQ-034 SHALL never assert latch_en and incr_en in the same cycle.
REQ-035 SHALL clear nchunks, ncycles and err in LATCH; nchunks and ncycles hold their values in IDLE.

Reset
REQ-036 SHALL, when rstn==0 at a clk edge, enter IDLE and zero all outputs and counters; reset mid-transfer abandons the transfer with no xfer_done pulse.

Structure
REQ-037 SHALL take its state encoding and the BYTES_PER_BURST=128 constant from the shared ddr_bw_pkg package.
REQ-038 SHALL instantiate no sub-modules; the timeout counter may be factored as sat_counter if reused.

Verification
REQ-039 SHALL verify: cfg nbursts=300, start, cmd_ready always 1 -> 3 commands (128, 128, 44 bursts at addr, +16384, +32768), nchunks=3, one xfer_done.
REQ-040 SHALL verify: nbursts=128 -> exactly 1 command of 128 and gen_done seen after the first drain.
REQ-041 SHALL verify: cmd_ready held low 10 cycles -> cmd_valid, cmd_addr and cmd_nbursts stable throughout; a single handshake.
REQ-042 SHALL verify: TIMEOUT_CYCLES=16 with gen_pending stuck high -> err=1 and xfer_done 17 cycles after DRAIN entry.
REQ-043 SHALL verify: abort in DRAIN -> FIN next cycle, xfer_done pulse, err=0; a subsequent start runs normally.
REQ-044 SHALL verify: rstn low mid-DRAIN -> IDLE, all outputs 0, no xfer_done.
